// File: rtl/booth_mult_8bit_if.sv
// Operand/result bundle between the operand registers, the Booth multiplier and the result bus.
// The master supplies the operands and start; the slave returns busy, the done pulse and the product.
interface booth_mult_8bit_if;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/booth_mult_8bit.sv
// Sequential 8x8 signed radix-2 Booth multiplier, one multiplier bit per cycle, 16-bit product.
// The CLA_8bit adder/subtractor beside it performs every add/subtract step.
module booth_mult_8bit (
  input  logic             clk,
  input  logic             rst_n,
  booth_mult_8bit_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  mr_q, mr_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  qr_q, qr_d;
  logic        q1_q, q1_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        add_ctrl;
  logic        do_arith;
  logic [7:0]  cla_sum;
  logic        cla_v;
  logic        cla_cout_unused;
  logic [7:0]  step_val;
  logic        step_sign;
  logic [7:0]  a_step;
  logic [7:0]  qr_step;
  logic        accept;

  // Booth pair {Qr[0], q_1}: 01 adds M, 10 subtracts M, 00/11 just shift.
  assign do_arith = qr_q[0] ^ q1_q;
  assign add_ctrl = ~qr_q[0] & q1_q;

  CLA_8bit u_cla (
    .A        (a_q),
    .B        (mr_q),
    .Add_ctrl (add_ctrl),
    .SUM      (cla_sum),
    .C_out    (cla_cout_unused),
    .v        (cla_v)
  );

  // SUM[7]^v recovers the true 9-bit sign when the 8-bit result overflows (e.g. M = -128).
  assign step_val  = do_arith ? cla_sum : a_q;
  assign step_sign = do_arith ? (cla_sum[7] ^ cla_v) : a_q[7];
  assign a_step    = {step_sign, step_val[7:1]};
  assign qr_step   = {step_val[0], qr_q[7:1]};

  assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d   = state_q;
    mr_d      = mr_q;
    a_d       = a_q;
    qr_d      = qr_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d = ST_CALC;
          mr_d    = bus.multiplicand;
          qr_d    = bus.multiplier;
          a_d     = 8'h00;
          q1_d    = 1'b0;
          cnt_d   = 3'd0;
        end
      end
      ST_CALC: begin
        a_d   = a_step;
        qr_d  = qr_step;
        q1_d  = qr_q[0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d   = ST_DONE;
          product_d = {a_step, qr_step};
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CALC);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mr_q      <= 8'h00;
      a_q       <= 8'h00;
      qr_q      <= 8'h00;
      q1_q      <= 1'b0;
      cnt_q     <= 3'd0;
      product_q <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mr_q      <= mr_d;
      a_q       <= a_d;
      qr_q      <= qr_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// 8-bit carry-lookahead adder/subtractor: Add_ctrl=1 gives A+B, Add_ctrl=0 gives A-B.
// v flags signed overflow (carry into bit 7 differs from carry out).
module CLA_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Add_ctrl,
  output logic [7:0] SUM,
  output logic       C_out,
  output logic       v
);
  logic [7:0] b_eff;
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       cin;

  assign b_eff = B ^ {8{~Add_ctrl}};
  assign cin   = ~Add_ctrl;
  assign c[0]  = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign g[gi]   = A[gi] & b_eff[gi];
      assign p[gi]   = A[gi] ^ b_eff[gi];
      assign SUM[gi] = p[gi] ^ c[gi];
    end

    // Each carry is a flat sum-of-products over g/p and cin, no ripple chain.
    for (gi = 1; gi <= 8; gi++) begin : g_carry
      logic carry;
      always_comb begin
        logic acc;
        logic prop;
        acc  = g[gi-1];
        prop = p[gi-1];
        for (int j = gi - 2; j >= 0; j--) begin
          acc  = acc | (prop & g[j]);
          prop = prop & p[j];
        end
        carry = acc | (prop & cin);
      end
      assign c[gi] = carry;
    end
  endgenerate

  assign C_out = c[8];
  assign v     = c[8] ^ c[7];
endmodule

// File: tb/tb_booth_mult_8bit.sv
// Directed and randomized checks of booth_mult_8bit against a plain signed-multiply reference.
module tb_booth_mult_8bit;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  booth_mult_8bit_if bus ();

  booth_mult_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int NB = 600;

  logic [7:0] corner_m [6] = '{8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01};
  logic [7:0] corner_q [6] = '{8'h80, 8'h7F, 8'h80, 8'hB3, 8'hFF, 8'h80};

  function automatic logic [15:0] ref_mul(input logic [7:0] m, input logic [7:0] q);
    int mi;
    int qi;
    int p;
    mi = int'($signed(m));
    qi = int'($signed(q));
    p  = mi * qi;
    return p[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s check did not hold", tag);
    end
  endtask

  task automatic run_mult(input logic [7:0] m, input logic [7:0] q, input bit inject, input string tag);
    int          acc_cyc;
    int          busy_cnt;
    bit          got;
    logic [15:0] exp;
    exp = ref_mul(m, q);
    @(negedge clk);
    acc_cyc          = cyc;
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt  = 0;
    got       = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (inject && k == 2) begin
        bus.start        = 1'b1;
        bus.multiplicand = 8'd9;
        bus.multiplier   = 8'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "/done_seen"}, 32'(got), 32'd1);
    // accept edge through the done cycle spans 9 clocks
    check({tag, "/latency"}, 32'(cyc - acc_cyc), 32'd9);
    check({tag, "/product"}, 32'(bus.product), 32'(exp));
    check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({tag, "/busy_in_done"}, 32'(bus.busy), 32'd0);
    $display("txn %s m=%h q=%h product=%h expected=%h", tag, m, q, bus.product, exp);
    @(negedge clk);
    check({tag, "/done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int          k;
    int          prev_cyc;
    bit          stable;
    bit          saw_done;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] exp;
    logic [15:0] last_prod;
    logic [15:0] exp_q [$];

    checks           = 0;
    failures         = 0;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = 8'h00;
    bus.multiplier   = 8'h00;

    #12;
    check("reset/busy", 32'(bus.busy), 32'd0);
    check("reset/done", 32'(bus.done), 32'd0);
    check("reset/product", 32'(bus.product), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_mult(8'd3, 8'd5, 1'b0, "m3_q5");
    run_mult(8'h80, 8'h80, 1'b0, "mneg128_qneg128");
    run_mult(8'h80, 8'h7F, 1'b0, "mneg128_q127");
    run_mult(8'h7F, 8'hFF, 1'b0, "m127_qneg1");
    run_mult(8'h00, 8'hB3, 1'b0, "m0_qneg77");
    run_mult(8'd3, 8'd5, 1'b1, "start_ignored_in_calc");

    // Abort mid-CALC with an asynchronous reset.
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 8'd3;
    bus.multiplier   = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort/busy", 32'(bus.busy), 32'd0);
    check("abort/done", 32'(bus.done), 32'd0);
    check("abort/product", 32'(bus.product), 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("abort/no_done_pulse", 32'(saw_done), 32'd0);
    $display("txn abort_mid_calc product=%h", bus.product);
    run_mult(8'd2, 8'hFD, 1'b0, "after_abort_m2_qneg3");

    // Back-to-back with start held high; new operands presented in each DONE cycle.
    @(negedge clk);
    m                = corner_m[0];
    q                = corner_q[0];
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.start        = 1'b1;
    exp_q.push_back(ref_mul(m, q));
    prev_cyc = 0;
    for (int n = 0; n < NB; n++) begin
      k         = 0;
      stable    = 1'b1;
      last_prod = bus.product;
      do begin
        @(negedge clk);
        k++;
        if (!bus.done && bus.product !== last_prod) stable = 1'b0;
      end while (!bus.done && k < 20);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check("b2b/done_seen", 32'(bus.done), 32'd1);
      check("b2b/product", 32'(bus.product), 32'(exp));
      check("b2b/product_held", 32'(stable), 32'd1);
      if (n > 0) check("b2b/spacing", 32'(cyc - prev_cyc), 32'd9);
      prev_cyc = cyc;
      $display("txn b2b#%0d m=%h q=%h product=%h expected=%h", n, bus.multiplicand, bus.multiplier, bus.product, exp);
      if (n < NB - 1) begin
        if (n + 1 < 6) begin
          m = corner_m[n+1];
          q = corner_q[n+1];
        end else begin
          m = 8'($urandom);
          q = 8'($urandom);
        end
        bus.multiplicand = m;
        bus.multiplier   = q;
        exp_q.push_back(ref_mul(m, q));
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b/idle_after", 32'(bus.done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
